// File: rtl/led_ctrl_pkg.sv
// Shared encodings and default geometry for the LED cursor controller.
// Optional feature macro used by the top level: LED_WRAP_EN.
package led_ctrl_pkg;

  // Round-robin pointer encoding: which direction wins the next tie.
  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam int LED_W = 16;
  localparam int POS_W = $clog2(LED_W);

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, mismatch counter that only
// lets a level through after it has held for DEBOUNCE_CYCLES consecutive
// cycles, and a single-cycle pulse on each accepted rising level.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_accept;

  assign w_mismatch = (r_sync2 != r_level);
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive mismatch cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_mismatch || w_accept) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Accept the new level and flag a press only on the rising transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && r_sync2;
      if (w_accept) begin
        r_level <= r_sync2;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_move_arbiter.sv
// Single-lit LED cursor controller: two debounced buttons feed a round-robin
// arbiter that issues at most one move per cycle; the position register is
// updated on the following edge and the one-hot bus is decoded from it.
// Optional feature macro: LED_WRAP_EN (boundary moves wrap around instead of
// being refused; move_blocked is then constant 0).
module led_move_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int N_LEDS          = LED_W,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int START_POS       = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      btnL,
  input  logic                      btnR,
  output logic [N_LEDS-1:0]         led,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      move_done,
  output logic                      move_blocked
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0] POS_MAX = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_RST = PW'(START_POS);
  localparam logic [N_LEDS-1:0] LED_ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

  logic          w_press_l;
  logic          w_press_r;
  logic          w_req_l;
  logic          w_req_r;
  logic          w_both;
  logic          w_grant_l;
  logic          w_grant_r;
  logic          w_done;
  logic [PW-1:0] w_next_pos;

  logic          r_pend_l;
  logic          r_pend_r;
  logic          r_rr_ptr;
  logic [PW-1:0] r_pos;
  logic          r_done;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btnL),
    .o_press (w_press_l)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (btnR),
    .o_press (w_press_r)
  );

  // A fresh press on an already-pending direction simply merges into it.
  assign w_req_l   = w_press_l | r_pend_l;
  assign w_req_r   = w_press_r | r_pend_r;
  assign w_both    = w_req_l & w_req_r;
  assign w_grant_l = w_req_l & (!w_req_r || (r_rr_ptr == DIR_L));
  assign w_grant_r = w_req_r & (!w_req_l || (r_rr_ptr == DIR_R));

  // Hold the losing request and hand the next tie to it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_l <= 1'b0;
      r_pend_r <= 1'b0;
      r_rr_ptr <= DIR_L;
    end else begin
      r_pend_l <= w_req_l & ~w_grant_l;
      r_pend_r <= w_req_r & ~w_grant_r;
      if (w_both) begin
        r_rr_ptr <= w_grant_l ? DIR_R : DIR_L;
      end
    end
  end

`ifdef LED_WRAP_EN

  // Resolve the granted move; boundaries wrap to the opposite end.
  always_comb begin
    w_next_pos = r_pos;
    w_done     = 1'b0;
    if (w_grant_l) begin
      w_done     = 1'b1;
      w_next_pos = (r_pos == POS_MAX) ? '0 : r_pos + PW'(1);
    end else if (w_grant_r) begin
      w_done     = 1'b1;
      w_next_pos = (r_pos == '0) ? POS_MAX : r_pos - PW'(1);
    end
  end

  assign move_blocked = 1'b0;

`else

  logic w_blocked;
  logic r_blocked;

  // Resolve the granted move; a boundary move is consumed but refused.
  always_comb begin
    w_next_pos = r_pos;
    w_done     = 1'b0;
    w_blocked  = 1'b0;
    if (w_grant_l) begin
      if (r_pos == POS_MAX) begin
        w_blocked = 1'b1;
      end else begin
        w_done     = 1'b1;
        w_next_pos = r_pos + PW'(1);
      end
    end else if (w_grant_r) begin
      if (r_pos == '0) begin
        w_blocked = 1'b1;
      end else begin
        w_done     = 1'b1;
        w_next_pos = r_pos - PW'(1);
      end
    end
  end

  // Refused-move pulse, aligned with the edge the move would have landed on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blocked <= 1'b0;
    end else begin
      r_blocked <= w_blocked;
    end
  end

  assign move_blocked = r_blocked;

`endif

  // Apply the granted move one edge after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= POS_RST;
      r_done <= 1'b0;
    end else begin
      r_pos  <= w_next_pos;
      r_done <= w_done;
    end
  end

  // Decoding from the position register keeps led exactly one-hot every cycle.
  always_comb begin
    led = LED_ONE << r_pos;
  end

  assign pos       = r_pos;
  assign move_done = r_done;

endmodule

// File: tb/tb_led_move_arbiter.sv
module tb_led_move_arbiter;

  typedef struct {
    logic       dir_l;
    logic [3:0] pos;
    logic       done;
    logic       blk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnL = 1'b0;
  logic        btnR = 1'b0;
  logic [15:0] led;
  logic [3:0]  pos;
  logic        move_done;
  logic        move_blocked;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pulse = 0;
  int   prev_pulse = 0;
  vec_t sb[$];
  vec_t tbl[16];
  int   n_tbl;

  led_move_arbiter #(
    .N_LEDS(16), .DEBOUNCE_CYCLES(4), .START_POS(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btnL(btnL), .btnR(btnR),
    .led(led), .pos(pos), .move_done(move_done), .move_blocked(move_blocked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard consumer: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (led !== (16'h0001 << pos)) begin
        errors++;
        $display("FAIL led_onehot: led=%h pos=%0d", led, pos);
      end
      if (move_done || move_blocked) begin
        vec_t e;
        prev_pulse = last_pulse;
        last_pulse = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: cyc=%0d done=%b blocked=%b pos=%0d",
                   cyc, move_done, move_blocked, pos);
        end else begin
          e = sb.pop_front();
          if ({move_done, move_blocked, pos} !== {e.done, e.blk, e.pos}) begin
            errors++;
            $display("FAIL move_result: got done=%b blk=%b pos=%0d, want done=%b blk=%b pos=%0d",
                     move_done, move_blocked, pos, e.done, e.blk, e.pos);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected moves never seen, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic press(input vec_t v);
    @(negedge clk);
    sb.push_back(v);
    if (v.dir_l) btnL = 1'b1;
    else         btnR = 1'b1;
    wait_cyc(10);
    btnL = 1'b0;
    btnR = 1'b0;
    wait_cyc(10);
    drain("press");
  endtask

  initial begin
    int t_rel;
    vec_t v;

    n_tbl = 0;
    tbl[n_tbl++] = '{1'b0, 4'd14, 1'b1, 1'b0};
    tbl[n_tbl++] = '{1'b1, 4'd15, 1'b1, 1'b0};
`ifdef LED_WRAP_EN
    tbl[n_tbl++] = '{1'b1, 4'd0,  1'b1, 1'b0};
    tbl[n_tbl++] = '{1'b0, 4'd15, 1'b1, 1'b0};
`else
    tbl[n_tbl++] = '{1'b1, 4'd15, 1'b0, 1'b1};
`endif
    for (int k = 0; k < 8; k++) tbl[n_tbl++] = '{1'b0, 4'(14 - k), 1'b1, 1'b0};

    // Reset and idle
    wait_cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_pos", 32'(pos), 32'd15);
    check("reset_led", 32'(led), 32'h8000);
    check("reset_pulses", {30'd0, move_done, move_blocked}, 32'd0);
    wait_cyc(100);
    check("idle_pos", 32'(pos), 32'd15);

    // Single presses, boundary, walk down to position 7
    for (int i = 0; i < n_tbl; i++) begin
      press(tbl[i]);
      check("table_pos", 32'(pos), 32'(tbl[i].pos));
    end
    check("at_pos7", 32'(pos), 32'd7);

    // Simultaneous presses: L wins first, then R wins the next tie
    @(negedge clk);
    v = '{1'b1, 4'd8, 1'b1, 1'b0}; sb.push_back(v);
    v = '{1'b0, 4'd7, 1'b1, 1'b0}; sb.push_back(v);
    btnL = 1'b1; btnR = 1'b1;
    wait_cyc(10);
    btnL = 1'b0; btnR = 1'b0;
    wait_cyc(10);
    drain("tie1");
    check("tie1_spacing", 32'(last_pulse - prev_pulse), 32'd1);

    @(negedge clk);
    v = '{1'b0, 4'd6, 1'b1, 1'b0}; sb.push_back(v);
    v = '{1'b1, 4'd7, 1'b1, 1'b0}; sb.push_back(v);
    btnL = 1'b1; btnR = 1'b1;
    wait_cyc(10);
    btnL = 1'b0; btnR = 1'b0;
    wait_cyc(10);
    drain("tie2");
    check("tie2_spacing", 32'(last_pulse - prev_pulse), 32'd1);
    check("tie2_pos", 32'(pos), 32'd7);

    // Glitches shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      btnR = 1'b1; wait_cyc(2);
      btnR = 1'b0; wait_cyc(2);
    end
    wait_cyc(20);
    check("glitch_pos", 32'(pos), 32'd7);

    // Reset lands just as the tie leaves R pending
    @(negedge clk);
    btnL = 1'b1; btnR = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    btnL = 1'b0; btnR = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pend_pos", 32'(pos), 32'd15);
    wait_cyc(30);
    check("rst_pend_after", 32'(pos), 32'd15);

    // Button held through reset counts as a fresh press
    rst_n = 1'b0;
    btnR = 1'b1;
    wait_cyc(3);
    v = '{1'b0, 4'd14, 1'b1, 1'b0}; sb.push_back(v);
    rst_n = 1'b1;
    t_rel = cyc;
    wait_cyc(12);
    btnR = 1'b0;
    wait_cyc(10);
    drain("held_rst");
    check("held_rst_latency", 32'(last_pulse - t_rel), 32'd7);
    check("held_rst_pos", 32'(pos), 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
